conv_encoder_pool: RTL and testbench

CONV_ENCODER_POOL -- requirements
Module: conv_encoder_pool

---
 rtl/conv_encoder_pkg.sv | 18 +
 rtl/conv_encoder_max2.sv | 25 ++
 rtl/conv_encoder_pool.sv | 117 +++++++++++
 tb/tb_conv_encoder_pool.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_encoder_pkg.sv
// Shared constants and FSM state encoding for the encoder max-pool stage.
package conv_encoder_pkg;

  localparam int COLS      = 64;
  localparam int ROWS      = 180;
  localparam int FILTERS   = 16;
  localparam int DW        = 18;
  localparam int POOL_COLS = 32;
  localparam int PLANE     = 5760;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVEN,
    ST_ODD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/conv_encoder_max2.sv
// Signed two-input max with optional ReLU clamp (CONV_ENCODER_POOL_RELU_EN).
module conv_encoder_max2 #(
  parameter int DW = 18
) (
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] y
);

  logic signed [DW-1:0] mx;

  function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] v);
    return v[DW-1] ? '0 : v;
  endfunction

  always_comb begin
    mx = (a > b) ? a : b;
`ifdef CONV_ENCODER_POOL_RELU_EN
    y = relu(mx);
`else
    y = mx;
`endif
  end

endmodule

// File: rtl/conv_encoder_pool.sv
// Horizontal 2:1 max-pool over a raster pixel stream, one filter plane after another.
// Optional ReLU after the max is enabled by defining CONV_ENCODER_POOL_RELU_EN.
module conv_encoder_pool #(
  parameter int COLS    = conv_encoder_pkg::COLS,
  parameter int ROWS    = conv_encoder_pkg::ROWS,
  parameter int FILTERS = conv_encoder_pkg::FILTERS,
  parameter int DW      = conv_encoder_pkg::DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_pixel,
  output logic signed [DW-1:0] out_pixel,
  output logic [12:0]          out_addr,
  output logic [3:0]           out_filter,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);
  import conv_encoder_pkg::*;

  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FW   = (FILTERS > 1) ? $clog2(FILTERS) : 1;
  localparam int HALF = COLS / 2;

  state_t               state;
  logic [CW-1:0]        col, col_nx;
  logic [RW-1:0]        row, row_nx;
  logic [FW-1:0]        filt, filt_nx;
  logic                 last_px;
  logic [12:0]          addr_w;
  logic signed [DW-1:0] hold;
  logic signed [DW-1:0] max_y;

  conv_encoder_max2 #(.DW(DW)) u_max2 (
    .a (hold),
    .b (in_pixel),
    .y (max_y)
  );

  always_comb begin
    col_nx  = col + CW'(1);
    row_nx  = row;
    filt_nx = filt;
    if (col == CW'(COLS - 1)) begin
      col_nx = '0;
      if (row == RW'(ROWS - 1)) begin
        row_nx  = '0;
        filt_nx = (filt == FW'(FILTERS - 1)) ? '0 : filt + FW'(1);
      end else begin
        row_nx = row + RW'(1);
      end
    end
    last_px = (col == CW'(COLS - 1)) && (row == RW'(ROWS - 1)) &&
              (filt == FW'(FILTERS - 1));
    addr_w  = 13'(row) * 13'(HALF) + 13'(col >> 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      col        <= '0;
      row        <= '0;
      filt       <= '0;
      hold       <= '0;
      out_pixel  <= '0;
      out_addr   <= '0;
      out_filter <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_EVEN;
            busy  <= 1'b1;
          end
        end
        ST_EVEN: begin
          if (in_valid) begin
            hold  <= in_pixel;
            col   <= col_nx;
            row   <= row_nx;
            filt  <= filt_nx;
            state <= ST_ODD;
          end
        end
        ST_ODD: begin
          if (in_valid) begin
            out_pixel  <= max_y;
            out_addr   <= addr_w;
            out_filter <= 4'(filt);
            out_valid  <= 1'b1;
            col        <= col_nx;
            row        <= row_nx;
            filt       <= filt_nx;
            // Final pair of the last plane: terminal until the next reset.
            if (last_px) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ST_EVEN;
            end
          end
        end
        ST_DONE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_pool.sv
// Scoreboard bench for conv_encoder_pool on a reduced 4x3x16 frame.
module tb_conv_encoder_pool;

  localparam int COLS    = 4;
  localparam int ROWS    = 3;
  localparam int FILTERS = 16;
  localparam int DW      = 18;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] in_pixel = '0;
  logic signed [DW-1:0] out_pixel;
  logic [12:0]          out_addr;
  logic [3:0]           out_filter;
  logic                 out_valid;
  logic                 busy;
  logic                 done;

  conv_encoder_pool #(
    .COLS(COLS), .ROWS(ROWS), .FILTERS(FILTERS), .DW(DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .out_pixel  (out_pixel),
    .out_addr   (out_addr),
    .out_filter (out_filter),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pixel;
    int addr;
    int filt;
    int done;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int m_col = 0, m_row = 0, m_filt = 0;
  bit m_odd = 0;
  int m_hold = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_max(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
`ifdef CONV_ENCODER_POOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return m;
  endfunction

  function automatic int rand_px();
    logic signed [DW-1:0] v;
    v = DW'($urandom);
    return int'(v);
  endfunction

  task automatic model_reset();
    m_col = 0; m_row = 0; m_filt = 0; m_odd = 0; m_hold = 0;
  endtask

  task automatic model_px(input int v, input bit use_hand, input int hand);
    exp_t e;
    if (!m_odd) begin
      m_hold = v;
      m_odd  = 1;
    end else begin
      e.pixel = use_hand ? hand : ref_max(m_hold, v);
      e.addr  = m_row * (COLS / 2) + (m_col >> 1);
      e.filt  = m_filt;
      e.done  = (m_col == COLS-1 && m_row == ROWS-1 && m_filt == FILTERS-1) ? 1 : 0;
      q.push_back(e);
      m_odd = 0;
    end
    if (m_col == COLS-1) begin
      m_col = 0;
      if (m_row == ROWS-1) begin
        m_row  = 0;
        m_filt = (m_filt == FILTERS-1) ? 0 : m_filt + 1;
      end else m_row++;
    end else m_col++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic raw_pulse(input int v);
    in_valid = 1'b1;
    in_pixel = DW'(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input int v, input bit use_hand, input int hand);
    model_px(v, use_hand, hand);
    raw_pulse(v);
  endtask

  task automatic pair(input int a, input int b, input bit use_hand, input int hand,
                      input int g1, input int g2);
    idle(g1);
    send(a, 0, 0);
    idle(g2);
    send(b, use_hand, hand);
    check("strobe_latency", int'(out_valid), 1);
    @(posedge clk); #1;
    check("strobe_width", int'(out_valid), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_strobe: got strobe pixel %0d addr %0d, expected none",
                 out_pixel, out_addr);
      end else begin
        exp_t e;
        e = q.pop_front();
        n_cmp++;
        if (int'(out_pixel) != e.pixel || int'(out_addr) != e.addr ||
            int'(out_filter) != e.filt || int'(done) != e.done) begin
          n_err++;
          $display("FAIL strobe: got px %0d addr %0d filt %0d done %0d expected px %0d addr %0d filt %0d done %0d",
                   out_pixel, out_addr, out_filter, done, e.pixel, e.addr, e.filt, e.done);
        end
      end
    end
  end

  initial begin
    int a, b, k;
    idle(3);
    check("rst_out_pixel", int'(out_pixel), 0);
    check("rst_out_addr", int'(out_addr), 0);
    check("rst_out_filter", int'(out_filter), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b1;
    idle(2);

    // in_valid while idle must be ignored
    raw_pulse(100); raw_pulse(-100); raw_pulse(7);
    idle(2);
    check("idle_busy", int'(busy), 0);

    pulse_start();
    check("start_busy", int'(busy), 1);
    pair(5, -3, 1, 5, 0, 0);
`ifdef CONV_ENCODER_POOL_RELU_EN
    pair(-7, -2, 1, 0, 1, 2);
    pair(-131072, -131072, 1, 0, 0, 0);
`else
    pair(-7, -2, 1, -2, 1, 2);
    pair(-131072, -131072, 1, -131072, 0, 0);
`endif
    pair(131071, -131072, 1, 131071, 0, 1);
    pair(9, 9, 1, 9, 0, 0);
    check("hold_pixel", int'(out_pixel), 9);
    check("hold_addr", int'(out_addr), 4);

    // reset with a half pair outstanding
    send(77, 0, 0);
    rst = 1'b0;
    model_reset();
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_out_addr", int'(out_addr), 0);
    idle(2);
    rst = 1'b1;
    idle(1);
    pulse_start();
    pair(1, 2, 1, 2, 0, 0);
    check("after_rst_addr", int'(out_addr), 0);

    // full frame with random gaps
    rst = 1'b0;
    model_reset();
    idle(2);
    rst = 1'b1;
    idle(1);
    pulse_start();
    k = 0;
    for (int p = 0; p < COLS * ROWS * FILTERS / 2; p++) begin
      a = rand_px();
      b = rand_px();
      if (p == 5) b = a;
      pair(a, b, 0, 0, $urandom_range(0, 2), $urandom_range(0, 2));
      if (p == 40) check("mid_frame_done", int'(done), 0);
      if (p == 40) check("mid_frame_busy", int'(busy), 1);
    end
    check("final_done", int'(done), 1);
    check("final_busy", int'(busy), 0);
    check("final_addr", int'(out_addr), ROWS * (COLS / 2) - 1);
    check("final_filter", int'(out_filter), FILTERS - 1);

    // activity after done must be ignored
    raw_pulse(3); raw_pulse(4); pulse_start(); raw_pulse(5); raw_pulse(6);
    idle(3);
    check("post_done_done", int'(done), 1);
    check("post_done_addr", int'(out_addr), ROWS * (COLS / 2) - 1);

    while (q.size() != 0 && k < 20) begin idle(1); k++; end
    check("scoreboard_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
